// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: one shared prescaled period counter, per-channel duty
// registers double-buffered so new duties take effect only at a period boundary.
module pwm_multi_channel #(
   parameter int CHANNELS = 16,
   parameter int RES      = 8,
   parameter int PRESC_W  = 8,
   parameter int CH_W     = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] en_out,
   input  logic [CHANNELS-1:0] en_pwm,
   input  logic [PRESC_W-1:0]  prescale_div,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_chan,
   input  logic [RES-1:0]      wr_duty,
   output logic [CHANNELS-1:0] out,
   output logic                period_start
);

   // Counter stops one short of all-ones so an all-ones duty is always high.
   localparam logic [RES-1:0] CNT_MAX = {{(RES-1){1'b1}}, 1'b0};

   logic [PRESC_W-1:0] prescale_cnt;
   logic [RES-1:0]     cnt;
   logic [RES-1:0]     shadow [CHANNELS];
   logic [RES-1:0]     active [CHANNELS];
   logic               tick;
   logic               commit;

   always_comb begin
      tick   = (prescale_cnt >= prescale_div);
      commit = tick && (cnt == CNT_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prescale_cnt <= '0;
         cnt          <= '0;
         out          <= '0;
         period_start <= 1'b0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         prescale_cnt <= tick ? '0 : prescale_cnt + PRESC_W'(1);
         if (tick)
            cnt <= commit ? '0 : cnt + RES'(1);
         period_start <= commit;
         // Out-of-range channel numbers match no loop index and are dropped.
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (commit)
               active[i] <= shadow[i];
            if (wr_en && (32'(wr_chan) == i))
               shadow[i] <= wr_duty;
            out[i] <= en_out[i] & (~en_pwm[i] | (cnt < active[i]));
         end
      end
   end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: static-mode vector table, directed
// period/duty/prescaler/reset sequences and a randomized run against a reference model.
module tb_pwm_multi_channel;

   localparam int CH     = 16;
   localparam int RES    = 8;
   localparam int PW     = 8;
   localparam int CW     = 5;
   localparam int PERIOD = 255;

   logic          clk = 1'b0;
   logic          rst;
   logic [CH-1:0] en_out;
   logic [CH-1:0] en_pwm;
   logic [PW-1:0] prescale_div;
   logic          wr_en;
   logic [CW-1:0] wr_chan;
   logic [RES-1:0] wr_duty;
   logic [CH-1:0] out;
   logic          period_start;

   pwm_multi_channel #(
      .CHANNELS(CH),
      .RES(RES),
      .PRESC_W(PW),
      .CH_W(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en_out(en_out),
      .en_pwm(en_pwm),
      .prescale_div(prescale_div),
      .wr_en(wr_en),
      .wr_chan(wr_chan),
      .wr_duty(wr_duty),
      .out(out),
      .period_start(period_start)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model: position within the period, prescale phase, duty arrays.
   int m_pc;
   int m_pos;
   int m_shadow [CH];
   int m_active [CH];

   typedef struct {
      logic [CH-1:0] eo;
      logic [CH-1:0] ep;
      logic [CH-1:0] exp_out;
   } vec_t;
   vec_t vecs [7];

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, actual, expected);
      end
   endtask

   // Predict the post-edge outputs from the current inputs, clock once, compare.
   task automatic cycle();
      logic [CH-1:0] eo;
      bit tk;
      bit cm;
      eo = '0;
      cm = 1'b0;
      if (rst) begin
         m_pc  = 0;
         m_pos = 0;
         for (int i = 0; i < CH; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
         end
      end else begin
         tk = (m_pc >= int'(prescale_div));
         for (int i = 0; i < CH; i++)
            eo[i] = en_out[i] && (!en_pwm[i] || (m_pos < m_active[i]));
         cm = tk && (m_pos == PERIOD - 1);
         if (cm) m_active = m_shadow;
         if (wr_en && int'(wr_chan) < CH) m_shadow[int'(wr_chan)] = int'(wr_duty);
         m_pc = tk ? 0 : m_pc + 1;
         if (tk) m_pos = (m_pos + 1) % PERIOD;
      end
      @(posedge clk);
      #1;
      cyc++;
      check("out", int'(out), int'(eo));
      check("period_start", int'(period_start), int'(cm));
   endtask

   task automatic wr(input int ch, input int duty);
      wr_en   = 1'b1;
      wr_chan = CW'(ch);
      wr_duty = RES'(duty);
      cycle();
      wr_en   = 1'b0;
   endtask

   task automatic wait_ps(input string name, input int bound, output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (period_start !== 1'b1 && n < bound);
      if (period_start !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s timeout actual=no_pulse expected=pulse_within_%0d", name, bound);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int hi;
      int lo;
      int hi4;

      vecs[0] = '{16'h0000, 16'h0000, 16'h0000};
      vecs[1] = '{16'hFFFF, 16'h0000, 16'hFFFF};
      vecs[2] = '{16'hFFFF, 16'hFFFF, 16'h0000};
      vecs[3] = '{16'hA5A5, 16'h0F0F, 16'hA0A0};
      vecs[4] = '{16'h1234, 16'h1200, 16'h0034};
      vecs[5] = '{16'h8001, 16'h0001, 16'h8000};
      vecs[6] = '{16'h0000, 16'hFFFF, 16'h0000};

      rst = 1'b1;
      en_out = '0;
      en_pwm = '0;
      prescale_div = '0;
      wr_en = 1'b0;
      wr_chan = '0;
      wr_duty = '0;
      m_pc = 0;
      m_pos = 0;
      repeat (2) cycle();
      check("reset_out", int'(out), 0);
      check("reset_ps", int'(period_start), 0);

      // First commit lands 255 clocks after reset release.
      rst = 1'b0;
      wait_ps("first_ps", 300, n);
      check("first_ps_gap", n, 255);

      // Static / disabled modes with all duties still zero.
      foreach (vecs[k]) begin
         en_out = vecs[k].eo;
         en_pwm = vecs[k].ep;
         cycle();
         check("vec_out", int'(out), int'(vecs[k].exp_out));
      end

      // 50% duty on ch0.
      en_out = 16'h0001;
      en_pwm = 16'h0001;
      repeat (9) cycle();
      wr(0, 8'h80);
      wait_ps("t2_commit", 300, n);
      hi = 0;
      lo = 0;
      for (int i = 0; i < PERIOD; i++) begin
         cycle();
         hi += int'(out[0]);
         lo += int'(period_start);
      end
      check("t2_high_clks", hi, 128);
      check("t2_ps_per_period", lo, 1);

      // Duty extremes and static-high mode.
      en_out = 16'h0007;
      en_pwm = 16'h0007;
      wr(1, 8'h00);
      wr(2, 8'hFF);
      en_out = 16'h000F;
      cycle();
      check("t3_static_high", int'(out[3]), 1);
      wait_ps("t3_commit", 300, n);
      hi = 0;
      lo = 0;
      for (int i = 0; i < 3 * PERIOD; i++) begin
         cycle();
         hi += int'(out[1]);
         lo += int'(!out[2]);
      end
      check("t3_duty0_high", hi, 0);
      check("t3_dutyff_low", lo, 0);

      // Write on the commit edge, then mid-period; out-of-range channel write.
      en_out = 16'h0030;
      en_pwm = 16'h0030;
      while (m_pos != PERIOD - 1) cycle();
      wr(5, 8'h40);
      check("t4_commit_cycle", int'(period_start), 1);
      hi = 0;
      hi4 = 0;
      for (int i = 0; i < PERIOD; i++) begin
         wr_en = 1'b0;
         if (i == 100) begin
            wr_en = 1'b1; wr_chan = 5'd5; wr_duty = 8'h10;
         end else if (i == 150) begin
            wr_en = 1'b1; wr_chan = 5'd20; wr_duty = 8'hAA;
         end
         cycle();
         hi += int'(out[5]);
         hi4 += int'(out[4]);
      end
      wr_en = 1'b0;
      check("t4_old_value_period", hi, 0);
      hi = 0;
      for (int i = 0; i < PERIOD; i++) begin
         cycle();
         hi += int'(out[5]);
         hi4 += int'(out[4]);
      end
      check("t4_last_write_wins", hi, 16);
      check("t4_chan20_ignored", hi4, 0);

      // Prescaler: divide by 4, then drop to divide by 2 while prescale_cnt=3.
      prescale_div = 8'd3;
      wait_ps("t5_sync", 2000, n);
      wait_ps("t5_gap", 2000, n);
      check("t5_gap_div3", n, 1020);
      n = 0;
      while (m_pc != 3 && n < 8) begin
         cycle();
         n++;
      end
      prescale_div = 8'd1;
      cycle();
      wait_ps("t5_sync2", 1200, n);
      wait_ps("t5_gap2", 1200, n);
      check("t5_gap_div1", n, 510);
      prescale_div = 8'd0;

      // Reset mid-period discards active duty.
      en_out = 16'h0001;
      en_pwm = 16'h0001;
      wr(0, 8'h80);
      wait_ps("t6_commit", 300, n);
      repeat (50) cycle();
      rst = 1'b1;
      cycle();
      check("t6_rst_out", int'(out), 0);
      check("t6_rst_ps", int'(period_start), 0);
      rst = 1'b0;
      hi = 0;
      for (int i = 0; i < 300; i++) begin
         cycle();
         hi += int'(out[0]);
      end
      check("t6_low_after_reset", hi, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            en_out = CH'($urandom);
            en_pwm = CH'($urandom);
         end
         if ($urandom_range(0, 499) == 0)
            prescale_div = PW'($urandom_range(0, 2));
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_chan = CW'($urandom_range(0, 31));
         case ($urandom_range(0, 3))
            0:       wr_duty = 8'h00;
            1:       wr_duty = 8'hFF;
            default: wr_duty = RES'($urandom);
         endcase
         rst = ($urandom_range(0, 999) == 0);
         cycle();
      end
      rst = 1'b0;
      wr_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
